clock_time_ctrl: RTL and testbench



---
 rtl/clock_time_ctrl.sv | 164 ++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - 1 Hz timebase, HH:MM:SS counters and three-button time-set FSM (option: BLINK_EN)
module clock_time_ctrl #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int AUTO_RETURN_S = 10
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       tick_1hz,
    output logic       blank_hr,
    output logic       blank_min
);

    localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int IW = (AUTO_RETURN_S > 1) ? $clog2(AUTO_RETURN_S + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(AUTO_RETURN_S - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    mode_t          state;
    mode_t          state_next;
    logic [DW-1:0]  div;
    logic [IW-1:0]  idle;
    logic           btn_any;
    logic           expire;
    logic           enter_set;
    logic           leave_set;
    logic           edit_en;

    assign btn_any = btn_mode | btn_up | btn_down;
    // Any button in the expiry cycle counts as activity and cancels the auto-return.
    assign expire  = (state != RUN) && tick_1hz && (idle == IDLE_LAST) && !btn_any;
    assign edit_en = (state != RUN) && !btn_mode && (btn_up ^ btn_down);
    assign mode    = state;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        enter_set  = 1'b0;
        leave_set  = 1'b0;
        case (state)
            RUN: begin
                if (btn_mode) begin
                    state_next = SET_HR;
                    enter_set  = 1'b1;
                end
            end
            SET_HR: begin
                if (btn_mode) begin
                    state_next = SET_MIN;
                    enter_set  = 1'b1;
                end else if (expire) begin
                    state_next = RUN;
                    leave_set  = 1'b1;
                end
            end
            SET_MIN: begin
                if (btn_mode || expire) begin
                    state_next = RUN;
                    leave_set  = 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Leaving set mode restarts the second so the first tick is a full period away.
    always_ff @(posedge clk_100MHz) begin
        if (reset || leave_set) begin
            div      <= '0;
            tick_1hz <= 1'b0;
        end else begin
            tick_1hz <= (div == DIV_LAST);
            div      <= (div == DIV_LAST) ? '0 : div + DIV_ONE;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            hours   <= '0;
            minutes <= '0;
            seconds <= '0;
        end else if (leave_set) begin
            seconds <= '0;
        end else if (state == RUN && tick_1hz) begin
            if (seconds == 6'd59) begin
                seconds <= '0;
                if (minutes == 6'd59) begin
                    minutes <= '0;
                    hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                end else begin
                    minutes <= minutes + 6'd1;
                end
            end else begin
                seconds <= seconds + 6'd1;
            end
        end else if (edit_en) begin
            if (state == SET_HR) begin
                if (btn_up) begin
                    hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                end else begin
                    hours <= (hours == 5'd0) ? 5'd23 : hours - 5'd1;
                end
            end else begin
                if (btn_up) begin
                    minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                end else begin
                    minutes <= (minutes == 6'd0) ? 6'd59 : minutes - 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset || state_next == RUN || enter_set || btn_any) begin
            idle <= '0;
        end else if (tick_1hz) begin
            idle <= idle + IDLE_ONE;
        end
    end

`ifdef BLINK_EN
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_HZ / 2 - 1);
    logic phase;

    // Cleared on entry so the field being edited starts out visible.
    always_ff @(posedge clk_100MHz) begin
        if (reset || enter_set) begin
            phase <= 1'b0;
        end else if (div == DIV_HALF || div == DIV_LAST) begin
            phase <= ~phase;
        end
    end

    assign blank_hr  = (state == SET_HR)  && phase;
    assign blank_min = (state == SET_MIN) && phase;
`else
    assign blank_hr  = 1'b0;
    assign blank_min = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - self-checking bench for clock_time_ctrl with a seconds-of-day reference model
module tb_clock_time_ctrl;

    localparam int CLK = 10;
    localparam int AUTO = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       tick_1hz;
    logic       blank_hr;
    logic       blank_min;

    int errors = 0;
    int checks = 0;

    clock_time_ctrl #(.CLK_HZ(CLK), .AUTO_RETURN_S(AUTO)) dut (
        .clk_100MHz(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .hours(hours),
        .minutes(minutes),
        .seconds(seconds),
        .mode(mode),
        .tick_1hz(tick_1hz),
        .blank_hr(blank_hr),
        .blank_min(blank_min)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: time as seconds-of-day, divider as cycles since the last second restart.
    int m_tod, m_cyc, m_idle, m_mode;
    bit m_tick, m_phase, armed;

    always @(posedge clk) begin : model
        bit any, enter, leave, expire;
        int h, mi, s, delta;
        if (reset) begin
            m_tod = 0; m_cyc = 0; m_idle = 0; m_mode = 0;
            m_tick = 0; m_phase = 0; armed = 1;
        end else if (armed) begin
            any = btn_mode | btn_up | btn_down;
            enter = 0;
            leave = 0;
            h = m_tod / 3600;
            mi = (m_tod / 60) % 60;
            s = m_tod % 60;
            expire = (m_mode != 0) && m_tick && (m_idle + 1 == AUTO) && !any;
            if (m_mode == 0) begin
                if (m_tick) m_tod = (m_tod + 1) % 86400;
                if (btn_mode) begin m_mode = 1; enter = 1; end
            end else if (btn_mode) begin
                if (m_mode == 1) begin m_mode = 2; enter = 1; end
                else begin m_mode = 0; leave = 1; end
            end else if (expire) begin
                m_mode = 0;
                leave = 1;
            end else if (btn_up != btn_down) begin
                delta = btn_up ? 1 : -1;
                if (m_mode == 1) h = (h + 24 + delta) % 24;
                else mi = (mi + 60 + delta) % 60;
                m_tod = h * 3600 + mi * 60 + s;
            end
            if (m_mode == 0 || enter || any) m_idle = 0;
            else if (m_tick) m_idle = m_idle + 1;
            if (enter) m_phase = 0;
            else if (m_cyc == CLK / 2 - 1 || m_cyc == CLK - 1) m_phase = !m_phase;
            if (leave) begin
                m_tod = m_tod - (m_tod % 60);
                m_cyc = 0;
                m_tick = 0;
            end else begin
                m_tick = (m_cyc == CLK - 1);
                m_cyc = (m_cyc + 1) % CLK;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("hours", hours, m_tod / 3600);
            chk("minutes", minutes, (m_tod / 60) % 60);
            chk("seconds", seconds, m_tod % 60);
            chk("mode", mode, m_mode);
            chk("tick_1hz", tick_1hz, m_tick);
`ifdef BLINK_EN
            chk("blank_hr", blank_hr, (m_mode == 1) && m_phase);
            chk("blank_min", blank_min, (m_mode == 2) && m_phase);
`else
            chk("blank_hr", blank_hr, 0);
            chk("blank_min", blank_min, 0);
`endif
        end
    end

    task automatic pulse(input bit m, input bit u, input bit d);
        btn_mode = m;
        btn_up = u;
        btn_down = d;
        @(negedge clk);
        btn_mode = 0;
        btn_up = 0;
        btn_down = 0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (tick_1hz !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("tick_wait", tick_1hz, 1);
    endtask

    initial begin : stim
        int n, nt, toggles;
        logic prev;
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_hms", {hours, minutes, seconds}, 0);
        chk("rst_mode", mode, 0);
        chk("rst_tick", tick_1hz, 0);
        chk("rst_blank", {blank_hr, blank_min}, 0);

        repeat (9) @(negedge clk);
        chk("tick_before_10", tick_1hz, 0);
        @(negedge clk);
        chk("tick_at_10", tick_1hz, 1);
        chk("sec_at_10", seconds, 0);
        @(negedge clk);
        chk("tick_after_10", tick_1hz, 0);
        chk("sec_after_tick", seconds, 1);

        pulse(1, 0, 0);
        chk("enter_set_hr", mode, 1);
        pulse(0, 1, 1);
        chk("updown_same_cycle", hours, 0);
        pulse(0, 0, 1);
        chk("hr_wrap_down", hours, 23);
        pulse(1, 1, 0);
        chk("mode_over_up_mode", mode, 2);
        chk("mode_over_up_min", minutes, 0);
        pulse(0, 0, 1);
        chk("min_wrap_down", minutes, 59);
        pulse(0, 1, 0);
        chk("min_wrap_up", minutes, 0);
        chk("min_wrap_no_carry", hours, 23);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        chk("exit_mode", mode, 0);
        chk("exit_seconds", seconds, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick_1hz !== 1'b1 && n < 20);
        chk("exit_tick_latency", n, 10);

        n = 0;
        while (seconds != 58 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_235958", {hours, minutes, seconds}, {5'd23, 6'd59, 6'd58});
        wait_tick();
        @(negedge clk);
        chk("time_235959", {hours, minutes, seconds}, {5'd23, 6'd59, 6'd59});
        wait_tick();
        @(negedge clk);
        chk("time_midnight", {hours, minutes, seconds}, 0);
        chk("midnight_mode", mode, 0);

        pulse(1, 0, 0);
        nt = 0;
        n = 0;
        while (mode == 2'd1 && n < 300) begin
            if (tick_1hz) nt++;
            @(negedge clk);
            n++;
        end
        chk("auto_return_mode", mode, 0);
        chk("auto_return_ticks", nt, 10);

        pulse(1, 0, 0);
        nt = 0;
        n = 0;
        while (n < 300) begin
            if (tick_1hz) begin
                nt++;
                if (nt == AUTO) break;
            end
            @(negedge clk);
            n++;
        end
        pulse(0, 1, 0);
        chk("button_beats_expiry_mode", mode, 1);
        chk("button_beats_expiry_hr", hours, 1);

        n = 0;
        while (hours != 12 && n < 30) begin pulse(0, 1, 0); n++; end
        pulse(1, 0, 0);
        n = 0;
        while (minutes != 34 && n < 70) begin pulse(0, 1, 0); n++; end
        chk("preset_1234", {mode, hours, minutes}, {2'd2, 5'd12, 6'd34});
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("midrst_hms", {hours, minutes, seconds}, 0);
        chk("midrst_mode", mode, 0);

        pulse(1, 0, 0);
        toggles = 0;
        prev = blank_hr;
        repeat (20) begin
            @(negedge clk);
            if (blank_hr !== prev) toggles++;
            prev = blank_hr;
        end
`ifdef BLINK_EN
        chk("blink_toggles", toggles, 4);
`else
        chk("blink_toggles", toggles, 0);
`endif
        chk("blink_min_off", blank_min, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
